// File: rtl/noc_pkg.sv
// Shared NoC definitions for the router mux path: flit type codes, the
// arbiter state encoding, default widths and the flit type extractor.
package noc_pkg;

  localparam int DATAW_DEF = 66;
  localparam int VCHW_DEF  = 2;
  localparam int PORTW_DEF = 2;

  localparam logic [1:0] FLIT_NONE = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_DATA = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_P0   = 2'b01;
  localparam logic [1:0] SEL_P1   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  function automatic logic [1:0] flit_type(input logic [DATAW_DEF-1:0] flit);
    return flit[DATAW_DEF-1 -: 2];
  endfunction

endpackage

// File: rtl/mux.sv
// 2:1 flit multiplexer steered by a one-hot select; an all-zero select
// drives zeros so an idle output never carries a stale flit.
module mux
  import noc_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int VCHW  = VCHW_DEF,
  parameter int PORTW = PORTW_DEF
) (
  input  logic [PORTW-1:0] sel,
  input  logic [DATAW-1:0] data_0,
  input  logic [DATAW-1:0] data_1,
  input  logic [VCHW-1:0]  vch_0,
  input  logic [VCHW-1:0]  vch_1,
  output logic [DATAW-1:0] data,
  output logic [VCHW-1:0]  vch
);

  always_comb begin
    data = {DATAW{1'b0}};
    vch  = {VCHW{1'b0}};
    if (sel[0]) begin
      data = data_0;
      vch  = vch_0;
    end else if (sel[1]) begin
      data = data_1;
      vch  = vch_1;
    end else begin
      data = {DATAW{1'b0}};
      vch  = {VCHW{1'b0}};
    end
  end

endmodule

// File: rtl/mux_arb.sv
// Packet arbiter for the 2:1 router mux: holds the grant from HEAD to TAIL,
// alternates round-robin between packets and registers the chosen flit.
module mux_arb
  import noc_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int VCHW  = VCHW_DEF,
  parameter int PORTW = PORTW_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata_0,
  input  logic [DATAW-1:0] idata_1,
  input  logic             ivalid_0,
  input  logic             ivalid_1,
  input  logic [VCHW-1:0]  ivch_0,
  input  logic [VCHW-1:0]  ivch_1,
  output logic             iready_0,
  output logic             iready_1,
  output logic [DATAW-1:0] odata,
  output logic             ovalid,
  output logic [VCHW-1:0]  ovch,
  input  logic             oready,
  output logic [PORTW-1:0] sel,
  output logic             oerr
);

  arb_state_e       state_q, state_d;
  logic             rr_q, rr_d;
  logic [DATAW-1:0] odata_q, odata_d;
  logic [VCHW-1:0]  ovch_q, ovch_d;
  logic             ovalid_q, ovalid_d;
  logic             oerr_q, oerr_d;

  logic [1:0]       type_0_s, type_1_s;
  logic             head_0_s, head_1_s, free_s, load_s;
  logic             iready_0_s, iready_1_s;
  logic [PORTW-1:0] win_s, sel_s;
  logic [DATAW-1:0] mux_data_s;
  logic [VCHW-1:0]  mux_vch_s;

  assign type_0_s = flit_type(idata_0);
  assign type_1_s = flit_type(idata_1);
  assign head_0_s = ivalid_0 && (type_0_s == FLIT_HEAD);
  assign head_1_s = ivalid_1 && (type_1_s == FLIT_HEAD);
  assign free_s   = !ovalid_q || oready;

  mux #(
    .DATAW (DATAW),
    .VCHW  (VCHW),
    .PORTW (PORTW)
  ) u_mux (
    .sel    (sel_s),
    .data_0 (idata_0),
    .data_1 (idata_1),
    .vch_0  (ivch_0),
    .vch_1  (ivch_1),
    .data   (mux_data_s),
    .vch    (mux_vch_s)
  );

  // rr only matters when two heads wait at once
  always_comb begin
    win_s = SEL_NONE;
    if (head_0_s && head_1_s) begin
      win_s = rr_q ? SEL_P1 : SEL_P0;
    end else if (head_0_s) begin
      win_s = SEL_P0;
    end else if (head_1_s) begin
      win_s = SEL_P1;
    end else begin
      win_s = SEL_NONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    sel_s      = SEL_NONE;
    iready_0_s = 1'b0;
    iready_1_s = 1'b0;
    load_s     = 1'b0;
    oerr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_s = win_s;
        if (ivalid_0 && !head_0_s) begin
          iready_0_s = 1'b1;
          oerr_d     = 1'b1;
        end else begin
          iready_0_s = win_s[0] && free_s;
        end
        if (ivalid_1 && !head_1_s) begin
          iready_1_s = 1'b1;
          oerr_d     = 1'b1;
        end else begin
          iready_1_s = win_s[1] && free_s;
        end
        if ((win_s != SEL_NONE) && free_s) begin
          load_s  = 1'b1;
          state_d = win_s[0] ? ST_LOCK0 : ST_LOCK1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK0: begin
        sel_s      = SEL_P0;
        iready_0_s = free_s;
        if (ivalid_0 && free_s) begin
          load_s = 1'b1;
          oerr_d = (type_0_s == FLIT_HEAD);
          if (type_0_s == FLIT_TAIL) begin
            state_d = ST_IDLE;
            rr_d    = 1'b1;
          end else begin
            state_d = ST_LOCK0;
          end
        end else begin
          state_d = ST_LOCK0;
        end
      end
      ST_LOCK1: begin
        sel_s      = SEL_P1;
        iready_1_s = free_s;
        if (ivalid_1 && free_s) begin
          load_s = 1'b1;
          oerr_d = (type_1_s == FLIT_HEAD);
          if (type_1_s == FLIT_TAIL) begin
            state_d = ST_IDLE;
            rr_d    = 1'b0;
          end else begin
            state_d = ST_LOCK1;
          end
        end else begin
          state_d = ST_LOCK1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A stalled flit stays put; a new accept always overwrites the register
  always_comb begin
    odata_d  = odata_q;
    ovch_d   = ovch_q;
    ovalid_d = ovalid_q;
    if (load_s) begin
      odata_d  = mux_data_s;
      ovch_d   = mux_vch_s;
      ovalid_d = 1'b1;
    end else if (oready) begin
      ovalid_d = 1'b0;
    end else begin
      ovalid_d = ovalid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      odata_q  <= {DATAW{1'b0}};
      ovch_q   <= {VCHW{1'b0}};
      ovalid_q <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      odata_q  <= odata_d;
      ovch_q   <= ovch_d;
      ovalid_q <= ovalid_d;
      oerr_q   <= oerr_d;
    end
  end

  // Nothing is granted or acknowledged while reset is held
  assign sel      = rst_ ? SEL_NONE : sel_s;
  assign iready_0 = iready_0_s && !rst_;
  assign iready_1 = iready_1_s && !rst_;
  assign odata    = odata_q;
  assign ovch     = ovch_q;
  assign ovalid   = ovalid_q;
  assign oerr     = oerr_q;

endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: packet-level reference model predicts handshakes and
// grants; accepted flits go to a scoreboard drained by an output monitor.
module tb_mux_arb;

  localparam int DW = 66;
  localparam int VW = 2;
  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic          clk = 1'b0;
  logic          rst_ = 1'b1;
  logic [DW-1:0] idata_0 = '0, idata_1 = '0;
  logic          ivalid_0 = 1'b0, ivalid_1 = 1'b0;
  logic [VW-1:0] ivch_0 = '0, ivch_1 = '0;
  logic          iready_0, iready_1;
  logic [DW-1:0] odata;
  logic          ovalid;
  logic [VW-1:0] ovch;
  logic          oready = 1'b1;
  logic [1:0]    sel;
  logic          oerr;

  always #5 clk = ~clk;

  mux_arb #(.DATAW(DW), .VCHW(VW), .PORTW(2)) dut (
    .clk(clk), .rst_(rst_),
    .idata_0(idata_0), .idata_1(idata_1),
    .ivalid_0(ivalid_0), .ivalid_1(ivalid_1),
    .ivch_0(ivch_0), .ivch_1(ivch_1),
    .iready_0(iready_0), .iready_1(iready_1),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .oready(oready),
    .sel(sel), .oerr(oerr)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [VW-1:0] vch;
  } flit_t;

  flit_t pq[2][$];
  flit_t sb[$];

  int errors = 0;
  int checks = 0;
  int owner = -1;
  int rr = 0;
  bit m_ovalid = 1'b0;
  bit m_err = 1'b0;
  bit mon_en = 1'b0;
  int vprob[2];
  int start[2];
  int stall_lo, stall_hi, rdy_prob;
  int scyc, ovalid_cycles;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_flit(input int p, input logic [1:0] ty, input logic [VW-1:0] vch);
    flit_t f;
    f.data = {ty, $urandom(), $urandom()};
    f.vch  = vch;
    pq[p].push_back(f);
  endtask

  task automatic add_packet(input int p, input int ndata, input logic [VW-1:0] vch, input bit tail);
    add_flit(p, T_HEAD, vch);
    for (int i = 0; i < ndata; i++) add_flit(p, T_DATA, vch);
    if (tail) add_flit(p, T_TAIL, vch);
  endtask

  // Output monitor: every transfer must match the oldest accepted flit
  initial begin
    flit_t f;
    logic [DW-1:0] prev_data;
    logic [VW-1:0] prev_vch;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_vch = '0;
    forever begin
      @(negedge clk);
      if (rst_ || !mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_ovalid", ovalid, 1'b1);
          check("hold_odata", odata, prev_data);
          check("hold_ovch", ovch, prev_vch);
        end
        if (ovalid && oready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out: got odata %0h, want no transfer (t=%0t)", odata, $time);
          end else begin
            f = sb.pop_front();
            check("odata", odata, f.data);
            check("ovch", ovch, f.vch);
          end
        end
        prev_stall = ovalid && !oready;
        prev_data = odata;
        prev_vch = ovch;
      end
    end
  end

  // One cycle: drive inputs, then compare handshakes against the packet rules
  task automatic step();
    bit v[2];
    logic [1:0] ty[2];
    bit cand[2];
    bit exp_ir[2];
    bit acc[2];
    int win;
    bit free, nerr;
    logic [1:0] exp_sel;
    flit_t f;
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      v[p] = (pq[p].size() > 0) && (scyc >= start[p]) && ($urandom_range(99) < vprob[p]);
      ty[p] = v[p] ? pq[p][0].data[DW-1 -: 2] : T_NONE;
    end
    ivalid_0 = v[0];
    idata_0  = v[0] ? pq[0][0].data : '0;
    ivch_0   = v[0] ? pq[0][0].vch : '0;
    ivalid_1 = v[1];
    idata_1  = v[1] ? pq[1][0].data : '0;
    ivch_1   = v[1] ? pq[1][0].vch : '0;
    oready = ((scyc >= stall_lo) && (scyc <= stall_hi)) ? 1'b0 : ($urandom_range(99) < rdy_prob);
    @(negedge clk);

    free = !m_ovalid || oready;
    nerr = 1'b0;
    exp_sel = 2'b00;
    win = -1;
    for (int p = 0; p < 2; p++) begin
      exp_ir[p] = 1'b0;
      acc[p] = 1'b0;
      cand[p] = v[p] && (ty[p] == T_HEAD);
    end
    if (owner < 0) begin
      if (cand[0] && cand[1]) win = rr;
      else if (cand[0]) win = 0;
      else if (cand[1]) win = 1;
      if (win >= 0) exp_sel = (win == 0) ? 2'b01 : 2'b10;
      for (int p = 0; p < 2; p++) begin
        if (v[p] && !cand[p]) begin
          exp_ir[p] = 1'b1;
          nerr = 1'b1;
        end else if (win == p && free) begin
          exp_ir[p] = 1'b1;
          acc[p] = 1'b1;
        end
      end
    end else begin
      exp_sel = (owner == 0) ? 2'b01 : 2'b10;
      exp_ir[owner] = free;
      if (v[owner] && free) begin
        acc[owner] = 1'b1;
        if (ty[owner] == T_HEAD) nerr = 1'b1;
      end
    end

    check("iready_0", iready_0, exp_ir[0]);
    check("iready_1", iready_1, exp_ir[1]);
    check("sel", sel, exp_sel);
    check("ovalid", ovalid, m_ovalid);
    check("oerr", oerr, m_err);
    if (ovalid) ovalid_cycles++;

    for (int p = 0; p < 2; p++) begin
      if (v[p] && exp_ir[p]) begin
        f = pq[p].pop_front();
        if (acc[p]) sb.push_back(f);
      end
    end
    if (owner < 0) begin
      if (win >= 0 && free) owner = win;
    end else if (acc[owner] && ty[owner] == T_TAIL) begin
      rr = 1 - owner;
      owner = -1;
    end
    m_ovalid = (acc[0] || acc[1]) ? 1'b1 : (oready ? 1'b0 : m_ovalid);
    m_err = nerr;
    scyc++;
  endtask

  task automatic run(input string name, input int max_cyc);
    int n;
    n = 0;
    scyc = 0;
    ovalid_cycles = 0;
    while ((pq[0].size() > 0 || pq[1].size() > 0 || sb.size() > 0 || m_ovalid) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %0d cycles, want fewer than %0d", name, n, max_cyc);
    end
    step();
    step();
  endtask

  task automatic setup(input int vp, input int rp, input int s0, input int s1, input int slo, input int shi);
    vprob[0] = vp;
    vprob[1] = vp;
    rdy_prob = rp;
    start[0] = s0;
    start[1] = s1;
    stall_lo = slo;
    stall_hi = shi;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ = 1'b1;
    oready = 1'b1;
    ivalid_0 = 1'b1;
    idata_0 = {T_HEAD, 64'h0};
    ivalid_1 = 1'b1;
    idata_1 = {T_HEAD, 64'h1};
    @(negedge clk);
    check("rst_iready_0", iready_0, 1'b0);
    check("rst_iready_1", iready_1, 1'b0);
    check("rst_sel", sel, 2'b00);
    @(posedge clk); #1;
    rst_ = 1'b0;
    ivalid_0 = 1'b0;
    ivalid_1 = 1'b0;
    @(negedge clk);
    check("post_rst_ovalid", ovalid, 1'b0);
    check("post_rst_odata", odata, '0);
    check("post_rst_ovch", ovch, '0);
    check("post_rst_oerr", oerr, 1'b0);
    check("post_rst_sel", sel, 2'b00);
    owner = -1;
    rr = 0;
    m_ovalid = 1'b0;
    m_err = 1'b0;
    pq[0].delete();
    pq[1].delete();
    sb.delete();
  endtask

  initial begin
    int p;
    do_reset();
    mon_en = 1'b1;

    // single 22-flit packet from port 1
    setup(100, 100, 0, 0, 1000, -1);
    add_packet(1, 20, 2'd2, 1'b1);
    run("single", 200);
    check("single_ovalid_cycles", ovalid_cycles, 22);

    // simultaneous heads after reset, then a second round
    do_reset();
    setup(100, 100, 0, 0, 1000, -1);
    add_packet(0, 2, 2'd1, 1'b1);
    add_packet(0, 1, 2'd1, 1'b1);
    add_packet(1, 1, 2'd3, 1'b1);
    add_packet(1, 2, 2'd3, 1'b1);
    run("contention", 200);

    // port 1 head arrives while port 0 is mid-packet
    setup(100, 100, 0, 3, 1000, -1);
    add_packet(0, 6, 2'd0, 1'b1);
    add_packet(1, 2, 2'd1, 1'b1);
    run("no_interleave", 200);

    // three cycles of downstream backpressure mid-packet
    setup(100, 100, 0, 0, 5, 7);
    add_packet(0, 8, 2'd2, 1'b1);
    run("backpressure", 200);

    // stray DATA while idle is acknowledged and dropped
    setup(100, 100, 0, 0, 1000, -1);
    add_flit(0, T_DATA, 2'd1);
    run("proto_err", 50);
    add_packet(0, 2, 2'd1, 1'b1);
    run("after_err", 50);

    // reset after five DATA flits truncates the packet
    setup(100, 100, 0, 0, 1000, -1);
    add_packet(1, 5, 2'd3, 1'b0);
    run("partial", 100);
    do_reset();
    add_packet(1, 3, 2'd0, 1'b1);
    run("fresh_head", 100);

    // randomized traffic with occasional stray flits
    for (int b = 0; b < 15; b++) begin
      setup(70, 75, $urandom_range(2), $urandom_range(2), 1000, -1);
      for (int k = 0; k < 4; k++) begin
        p = $urandom_range(1);
        if ($urandom_range(9) == 0) add_flit(p, T_DATA, 2'd0);
        add_packet(p, $urandom_range(4), 2'($urandom_range(3)), 1'b1);
      end
      run("random", 2000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
